// File: rtl/inst_fetch_cache.sv
// inst_fetch_cache: direct-mapped one-word-per-line I-cache with SRAM-like refill bus
module inst_fetch_cache #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cache_call_begin,
    input  logic [31:0] pc,
    output logic        cache_return_ready,
    output logic [31:0] cache_return_instruction,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;
    typedef enum logic [2:0] {IDLE, LOOKUP, REQ, WAIT, RESP} state_t;
    state_t state, next;
    logic [31:2] pc_q;
    logic [LINES-1:0] valid;
    logic [TAG_BITS-1:0] tag_mem [LINES];
    logic [31:0] data_mem [LINES];
    logic [31:0] paddr, instr_d, addr_d;
    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0] tag;
    logic cacheable, hit, fill, ready_d, req_d;
    logic unused_pc;
    assign unused_pc = &{1'b0, pc[1:0]};
    assign paddr = {3'b000, pc_q[28:2], 2'b00};
    assign idx = paddr[INDEX_BITS+1:2];
    assign tag = paddr[31:INDEX_BITS+2];
    assign cacheable = pc_q[31:29] == 3'b100;
    assign hit = cacheable && valid[idx] && tag_mem[idx] == tag;
    assign fill = state == WAIT && inst_data_ok && cacheable;
    // state, registered outputs and valid bits; outputs are loaded from the next-cycle values
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cache_return_ready <= 1'b0;
            cache_return_instruction <= '0;
            inst_req <= 1'b0;
            inst_addr <= '0;
            valid <= '0;
        end else begin
            state <= next;
            cache_return_ready <= ready_d;
            cache_return_instruction <= instr_d;
            inst_req <= req_d;
            inst_addr <= addr_d;
            if (fill) valid[idx] <= 1'b1;
        end
        if (state == IDLE && cache_call_begin) pc_q <= pc[31:2];
    end
    // tag and data arrays need no reset; valid bits guard them
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[idx] <= tag;
            data_mem[idx] <= inst_rdata;
        end
    end
    // next-state logic; call_begin and data_ok only matter in IDLE and WAIT respectively
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = cache_call_begin ? LOOKUP : IDLE;
            LOOKUP:  next = hit ? RESP : REQ;
            REQ:     next = inst_addr_ok ? WAIT : REQ;
            WAIT:    next = inst_data_ok ? RESP : WAIT;
            default: next = IDLE;
        endcase
    end
    // output values for the coming cycle; instruction bus is zero outside the ready pulse
    always_comb begin
        ready_d = next == RESP;
        instr_d = ready_d ? (state == LOOKUP ? data_mem[idx] : inst_rdata) : '0;
        req_d = next == REQ;
        addr_d = req_d ? paddr : '0;
    end
endmodule

// File: tb/tb_inst_fetch_cache.sv
// tb_inst_fetch_cache: directed vector bench for the instruction fetch cache
module tb_inst_fetch_cache;
    logic clk = 0, reset = 1, cache_call_begin = 0, inst_addr_ok = 0, inst_data_ok = 0;
    logic [31:0] pc = 0, inst_rdata = 0;
    logic cache_return_ready, inst_req;
    logic [31:0] cache_return_instruction, inst_addr;
    int tests = 0, fails = 0;

    inst_fetch_cache #(.INDEX_BITS(6)) dut (
        .clk(clk), .reset(reset), .cache_call_begin(cache_call_begin), .pc(pc),
        .cache_return_ready(cache_return_ready), .cache_return_instruction(cache_return_instruction),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pc;
        int          ao;
        int          dgap;
        logic [31:0] rdata;
        int          extra_call;
        logic        exp_req;
        logic [31:0] exp_addr;
        int          exp_rdy;
        logic [31:0] exp_ins;
    } vec_t;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", n, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one fetch over a fixed 12-cycle window; k counts cycles from the call_begin cycle
    task automatic run_fetch(input vec_t v);
        int rdy = -1, pulses = 0, acc = -1, nz = 0;
        logic [31:0] ins = 0, a0 = 0;
        bit seen = 0, stable = 1;
        for (int k = 0; k < 12; k++) begin
            cache_call_begin = (k == 0) || (k == v.extra_call);
            pc = v.pc;
            inst_data_ok = acc >= 0 && k == acc + v.dgap;
            inst_rdata = inst_data_ok ? v.rdata : 32'hdeaddead;
            inst_addr_ok = inst_req && k >= v.ao && acc < 0;
            if (inst_addr_ok) acc = k;
            if (inst_req) begin
                if (!seen) a0 = inst_addr;
                else if (inst_addr !== a0) stable = 0;
                seen = 1;
            end
            if (cache_return_ready) begin
                pulses++;
                if (rdy < 0) begin
                    rdy = k;
                    ins = cache_return_instruction;
                end
            end else if (cache_return_instruction !== 0) nz++;
            step();
        end
        cache_call_begin = 0;
        inst_addr_ok = 0;
        inst_data_ok = 0;
        chk({v.name, " req"}, 32'(seen), 32'(v.exp_req));
        if (v.exp_req) begin
            chk({v.name, " addr"}, a0, v.exp_addr);
            chk({v.name, " addr_stable"}, 32'(stable), 32'd1);
        end
        chk({v.name, " ready_cycle"}, 32'(rdy), 32'(v.exp_rdy));
        chk({v.name, " instr"}, ins, v.exp_ins);
        chk({v.name, " pulses"}, 32'(pulses), 32'd1);
        chk({v.name, " bus_zero"}, 32'(nz), 32'd0);
    endtask

    task automatic check_idle_outputs(input string n);
        chk({n, " ready"}, 32'(cache_return_ready), 32'd0);
        chk({n, " instr"}, cache_return_instruction, 32'd0);
        chk({n, " req"}, 32'(inst_req), 32'd0);
        chk({n, " addr"}, inst_addr, 32'd0);
    endtask

    task automatic quiet_window(input string n, input int cycles);
        int bad = 0;
        for (int k = 0; k < cycles; k++) begin
            if (cache_return_ready || cache_return_instruction !== 0 || inst_req) bad++;
            step();
        end
        chk(n, 32'(bad), 32'd0);
    endtask

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{"cold_80000000", 32'h80000000, 2, 1, 32'h11111111, -1, 1, 32'h00000000, 4, 32'h11111111};
        vecs[1]  = '{"boot_bfc00000", 32'hbfc00000, 3, 2, 32'h3c1d0001, -1, 1, 32'h1fc00000, 6, 32'h3c1d0001};
        vecs[2]  = '{"boot_again",    32'hbfc00000, 3, 2, 32'h3c1d0001, -1, 1, 32'h1fc00000, 6, 32'h3c1d0001};
        vecs[3]  = '{"fill_80001004", 32'h80001004, 2, 1, 32'h24020005, -1, 1, 32'h00001004, 4, 32'h24020005};
        vecs[4]  = '{"hit_80001004",  32'h80001004, 2, 1, 32'h0badf00d, -1, 0, 32'h0,        2, 32'h24020005};
        vecs[5]  = '{"fill_80000010", 32'h80000010, 2, 1, 32'haaaa0001, -1, 1, 32'h00000010, 4, 32'haaaa0001};
        vecs[6]  = '{"hit_80000010",  32'h80000010, 2, 1, 32'h0badf00d, -1, 0, 32'h0,        2, 32'haaaa0001};
        vecs[7]  = '{"evict_80000110",32'h80000110, 2, 1, 32'hbbbb0002, -1, 1, 32'h00000110, 4, 32'hbbbb0002};
        vecs[8]  = '{"hit_80000110",  32'h80000110, 2, 1, 32'h0badf00d, -1, 0, 32'h0,        2, 32'hbbbb0002};
        vecs[9]  = '{"refill_0010",   32'h80000010, 2, 1, 32'haaaa0003, -1, 1, 32'h00000010, 4, 32'haaaa0003};
        vecs[10] = '{"uncached_alias",32'ha0000010, 2, 1, 32'hcccc0004, -1, 1, 32'h00000010, 4, 32'hcccc0004};
        vecs[11] = '{"hit_after_alias",32'h80000010,2, 1, 32'h0badf00d, -1, 0, 32'h0,        2, 32'haaaa0003};
        vecs[12] = '{"call_in_wait",  32'h80002000, 2, 3, 32'h12345678,  4, 1, 32'h00002000, 6, 32'h12345678};
        vecs[13] = '{"hit_80002000",  32'h80002000, 2, 1, 32'h0badf00d, -1, 0, 32'h0,        2, 32'h12345678};
        vecs[14] = '{"slow_addr_ok",  32'h80000004, 5, 1, 32'h0f0f0f0f, -1, 1, 32'h00000004, 7, 32'h0f0f0f0f};
        vecs[15] = '{"pc_low_bits",   32'h80000007, 2, 1, 32'h0badf00d, -1, 0, 32'h0,        2, 32'h0f0f0f0f};

        reset = 1;
        repeat (3) step();
        reset = 0;
        check_idle_outputs("reset");
        step();
        check_idle_outputs("post_reset");

        foreach (vecs[i]) run_fetch(vecs[i]);

        // stray data_ok in IDLE: no response, no fill of 80000020's line
        inst_data_ok = 1;
        inst_rdata = 32'h55555555;
        step();
        step();
        inst_data_ok = 0;
        quiet_window("stray_data_ok_quiet", 4);
        run_fetch('{"after_stray", 32'h80000020, 2, 1, 32'h66660001, -1, 1, 32'h00000020, 4, 32'h66660001});

        // reset while WAIT: the late data_ok is dropped and all lines become invalid
        pc = 32'h80000040;
        cache_call_begin = 1;
        step();
        cache_call_begin = 0;
        step();
        chk("rst_wait req", 32'(inst_req), 32'd1);
        inst_addr_ok = 1;
        step();
        inst_addr_ok = 0;
        reset = 1;
        step();
        reset = 0;
        check_idle_outputs("rst_wait outputs");
        inst_data_ok = 1;
        inst_rdata = 32'h99999999;
        step();
        inst_data_ok = 0;
        quiet_window("rst_wait late_data_ok", 4);
        run_fetch('{"miss_after_rst", 32'h80001004, 2, 1, 32'h77770001, -1, 1, 32'h00001004, 4, 32'h77770001});
        run_fetch('{"miss_0010_rst",  32'h80000010, 2, 1, 32'h77770002, -1, 1, 32'h00000010, 4, 32'h77770002});
        run_fetch('{"miss_0040_rst",  32'h80000040, 2, 1, 32'h77770003, -1, 1, 32'h00000040, 4, 32'h77770003});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/inst_fetch_cache.md
# inst_fetch_cache

Instruction-side cache that sits directly downstream of the PC/IF register. It accepts a one-cycle fetch pulse plus the current PC and returns one instruction word with a one-cycle ready pulse. It serves kseg0 fetches from a direct-mapped, one-word-per-line array. Misses and uncached fetches go out on an SRAM-like instruction bus (req/addr_ok/data_ok).

## Interface
Parameters:
- INDEX_BITS, 6, log2 of line count (64 lines of one 32-bit word each)

Ports:
- clk  in  1  single clock; all state changes on posedge
- reset  in  1  synchronous, active-high
- cache_call_begin  in  1  one-cycle fetch request pulse; pc is valid in the same cycle
- pc  in  32  virtual fetch address
- cache_return_ready  out  1  one-cycle pulse: instruction valid
- cache_return_instruction  out  32  fetched word while ready=1, otherwise forced to 32'h0 (the consumer ORs this bus)
- inst_req  out  1  bus request, held until accepted
- inst_addr  out  32  physical word address, stable while inst_req=1
- inst_addr_ok  in  1  request accepted this cycle
- inst_data_ok  in  1  read data valid this cycle
- inst_rdata  in  32  read data

## Operation
- Address map:
  - Physical address is {3'b000, pc[28:2], 2'b00]}; pc[1:0] is ignored.
  - A fetch is cacheable iff pc[31:29]==3'b100 (kseg0). All other segments, including kseg1 (reset vector 32'hbfc00000), are uncached.
- Array: per line, a valid bit, a tag (paddr[31:INDEX_BITS+2]) and a data word; index is paddr[INDEX_BITS+1:2].
- FSM states: IDLE, LOOKUP, REQ, WAIT, RESP.
  - IDLE: on cache_call_begin, latch pc and go to LOOKUP. Otherwise stay.
  - LOOKUP:
    - Cacheable hit: latch the array word and go to RESP.
    - Miss or uncached: go to REQ.
  - REQ: inst_req=1 with inst_addr=latched physical address. On inst_addr_ok, go to WAIT.
  - WAIT: on inst_data_ok, latch inst_rdata. If the fetch is cacheable, write valid=1, tag and data into the indexed line (overwriting, no victim check). Go to RESP.
  - RESP: cache_return_ready=1 and cache_return_instruction=latched word for exactly this cycle; go to IDLE.
- cache_call_begin outside IDLE is ignored: no latch and no second response. The PC stage never issues one.
- inst_data_ok outside WAIT is ignored. The slave guarantees data_ok arrives at least one cycle after addr_ok.
- Uncached fetches never read or write the array. An uncached fetch whose address would index a valid line leaves that line unchanged.
- There is exactly one outstanding bus transaction at a time.

## Timing
- Reset values:
  - State is IDLE.
  - cache_return_ready=0, cache_return_instruction=0, inst_req=0, inst_addr=0.
  - All valid bits are cleared. Tag and data contents are don't-care.
- Reset mid-operation (any state): apply the reset values above. A data_ok belonging to an abandoned transaction then arrives in IDLE and is dropped.
- Hit latency: call_begin in cycle T, LOOKUP in T+1, cache_return_ready=1 in T+2.
- Miss/uncached latency:
  - inst_req rises in T+2.
  - With addr_ok in cycle A (A≥T+2) and data_ok in cycle D (D≥A+1), ready=1 in D+1.
- inst_req and inst_addr hold steady from REQ entry through the addr_ok cycle. inst_req drops in the cycle after addr_ok.
- Back-to-back fetches: the earliest new call_begin is accepted in the cycle after the RESP pulse, so hit-to-hit spacing is 3 cycles.
- All outputs are registered. There is no combinational path from the bus inputs to cache_return_*.

## Test plan
- Reset held 3 cycles then released:
  - All outputs are 0 and state is IDLE.
  - A subsequent kseg0 fetch of 32'h80000000 misses (inst_req=1, inst_addr=32'h00000000).
- Uncached boot fetch:
  - call_begin with pc=32'hbfc00000, addr_ok in T+3, data_ok in T+5 with rdata=32'h3c1d0001.
  - Required response: inst_addr=32'h1fc00000, ready pulse in T+6 carrying 32'h3c1d0001, instruction bus 0 in every other cycle.
  - Repeating the same fetch misses again.
- kseg0 fill then hit:
  - Fetch 32'h80001004 misses; data 32'h24020005 is filled.
  - A second fetch of the same address issues no inst_req and pulses ready in T+2 with 32'h24020005.
- Conflict eviction (INDEX_BITS=6):
  - Fill 32'h80000010, then fetch 32'h80000110 (same index, different tag); it misses and overwrites the line.
  - A refetch of 32'h80000010 misses.
- Protocol edges:
  - call_begin asserted during WAIT is ignored; exactly one ready pulse is produced.
  - A stray data_ok in IDLE produces no ready pulse and no array write.
- Reset in WAIT:
  - Assert reset after addr_ok, before data_ok; the late data_ok is ignored.
  - All lines are invalid afterwards: a previously filled address misses.
